block_slider: RTL
=================

# block_slider

Animates one game tile's top-left screen position between cells of the 4x4 board and feeds the tile-rectangle stage (`ix`, `iy`, `on`) directly. On `start` it latches a destination cell and, once per video frame, moves the position toward the cell's pixel origin until it arrives. It then pulses `done`. The block sits between game logic, which issues moves, and the rectangle/renderer path, which consumes coordinates.

## Interface
- `ORIGIN_X`, default 120: pixel x of cell column 0.
- `ORIGIN_Y`, default 40: pixel y of cell row 0.
- `CELL`, default 100: cell pitch in pixels, for 94-px tiles plus a 6-px gap.
- `STEP`, default 8: base pixels moved per axis per frame tick; must be ≥1.
- `pixel_clk`  in  1  the single clock; everything is registered on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse, once per frame (start of vblank).
- `start`  in  1  request a slide to (`dst_col`, `dst_row`); sampled only in IDLE.
- `spawn`  in  1  teleport to (`dst_col`, `dst_row`) with no animation; sampled only in IDLE.
- `dst_col`  in  2  destination column, 0–3.
- `dst_row`  in  2  destination row, 0–3.
- `ix`  out  11  current tile x, registered.
- `iy`  out  11  current tile y, registered.
- `on`  out  1  high while moving; used downstream as the highlight inset.
- `busy`  out  1  high in MOVE and DONE.
- `done`  out  1  one-cycle pulse when the tile arrives at its destination.

## Operation
- Target computation, done at latch time: `tx = ORIGIN_X + dst_col*CELL`, `ty = ORIGIN_Y + dst_row*CELL`.
  - The defaults give a maximum of 420; this must fit in 11 bits.
  - No signed arithmetic is stored; direction is determined per axis by comparison.
- States:
  - IDLE: `busy=0`, `on=0`.
  - MOVE: `busy=1`, `on=1`.
  - DONE: `busy=1`, `on=0`, `done=1`, lasts exactly one cycle.
- IDLE transitions:
  - `spawn=1`: load `ix=tx`, `iy=ty` and stay in IDLE. No `done` pulse.
  - else `start=1` with the target equal to the current position: go to DONE.
  - else `start=1`: latch `tx`/`ty`, go to MOVE.
- MOVE behaviour:
  - Position changes only on cycles where `frame_tick=1`.
  - Each axis moves by `min(step, |target − pos|)` toward its target. Both axes move in the same tick, so diagonal moves are legal.
  - If the tick makes both axes equal their targets: go to DONE. Otherwise stay in MOVE.
- DONE always returns to IDLE on the next cycle.
- Input handling outside IDLE:
  - `start` and `spawn` are ignored in MOVE and DONE; there is no queueing.
  - `dst_*` are not re-sampled mid-move.
- Simultaneous inputs in IDLE:
  - `spawn` and `start` together: `spawn` wins.
  - `start` and `frame_tick` together: the tick is ignored, and the first movement happens on the next tick.
- Overshoot must never occur, whatever the `STEP`/`CELL` ratio.

## Timing
- Values forced by reset: `ix=ORIGIN_X`, `iy=ORIGIN_Y`, state IDLE, `on=0`, `busy=0`, `done=0`, step = `STEP`.
- Reset while in MOVE or DONE aborts the slide and returns to these reset values; no `done` pulse is issued.
- `start` sampled at edge N → `busy` and `on` high after edge N.
- `frame_tick` sampled at edge M during MOVE → the new `ix`/`iy` are visible after edge M.
- If that tick reaches the target, `done=1` after edge M+1, and `busy` falls after edge M+2.
- `start` to an already-occupied cell: `done` pulses after edge N+1, with no frame tick needed.
- `spawn` at edge N → the new `ix`/`iy` are visible after edge N.
- Latency in ticks is `ceil(max(|dx|,|dy|)/step)` frame ticks. The accelerated mode (Configuration) changes this.

## Configuration
- `SLIDE_ACCEL_EN` defined:
  - The per-move step starts at `STEP` and doubles after each applied tick.
  - It saturates at `4*STEP`.
  - It resets to `STEP` on every `start` and on `rst`.
  - The step register needs 2 extra bits of headroom.
- `SLIDE_ACCEL_EN` undefined:
  - The step is the constant `STEP`.
  - No step register is built.

## Test plan
- Reset check: assert `rst` for 2 cycles → `ix=120`, `iy=40`, `on=0`, `busy=0`, `done=0`. Assert `rst` again mid-MOVE → same values, no `done`.
- Constant-step slide (no macro): from (0,0), `start` to col 1 row 0 → `ix` goes 128, 136, …, 216, 220 over 13 frame ticks; `iy` stays 40; one `done` pulse; `on` high throughout.
- Diagonal slide with no overshoot: with `STEP=8`, from col 0 row 0 to col 3 row 3 → `ix`/`iy` reach 420/340 after 38 ticks. Final tick steps are 4 px. Values are never beyond target.
- Ignored and priority inputs:
  - `start` to the current cell → `done` after 2 edges, `ix`/`iy` unchanged.
  - `start` during MOVE → ignored.
  - `spawn` and `start` in the same cycle → position jumps, no `done`.
- Accelerated slide (`SLIDE_ACCEL_EN`): from col 0 to col 1 → `ix` goes 128, 144, 176, 208, 220 in 5 ticks. The next move restarts at step 8.

Source files
------------

// File: rtl/block_slider.sv
`default_nettype none
// ============================================================================
// Module   : block_slider
// Purpose  : Slides one 4x4-board tile toward a destination cell once per frame.
//            Optional macro SLIDE_ACCEL_EN doubles the step each tick (max 4*STEP).
// Revision : 1.0 - initial release
// ============================================================================
module block_slider #(
    parameter int ORIGIN_X = 120,
    parameter int ORIGIN_Y = 40,
    parameter int CELL     = 100,
    parameter int STEP     = 8
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        spawn,
    input  logic [1:0]  dst_col,
    input  logic [1:0]  dst_row,
    output logic [10:0] ix,
    output logic [10:0] iy,
    output logic        on,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [10:0] r_tx;
    logic [10:0] r_ty;
    logic [10:0] w_tx;
    logic [10:0] w_ty;
    logic [10:0] w_step;
    logic [10:0] w_nx;
    logic [10:0] w_ny;

    assign w_tx = 11'(ORIGIN_X) + 11'(dst_col) * 11'(CELL);
    assign w_ty = 11'(ORIGIN_Y) + 11'(dst_row) * 11'(CELL);

`ifdef SLIDE_ACCEL_EN
    localparam int SW = $clog2(STEP + 1) + 2;
    logic [SW-1:0] r_step;
    assign w_step = 11'(r_step);
`else
    assign w_step = 11'(STEP);
`endif

    // Clamp each axis to its target so no STEP/CELL ratio can overshoot.
    function automatic logic [10:0] approach(input logic [10:0] pos,
                                             input logic [10:0] tgt,
                                             input logic [10:0] stp);
        if (pos < tgt)
            approach = ((tgt - pos) > stp) ? pos + stp : tgt;
        else
            approach = ((pos - tgt) > stp) ? pos - stp : tgt;
    endfunction

    assign w_nx = approach(ix, r_tx, w_step);
    assign w_ny = approach(iy, r_ty, w_step);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            ix      <= 11'(ORIGIN_X);
            iy      <= 11'(ORIGIN_Y);
            r_tx    <= 11'(ORIGIN_X);
            r_ty    <= 11'(ORIGIN_Y);
            on      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SLIDE_ACCEL_EN
            r_step  <= SW'(STEP);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (spawn) begin
                        ix <= w_tx;
                        iy <= w_ty;
                    end else if (start) begin
                        // Arrival is checked in MOVE, so a start to the
                        // current cell still reports done one cycle later.
                        r_tx    <= w_tx;
                        r_ty    <= w_ty;
                        r_state <= S_MOVE;
                        busy    <= 1'b1;
                        on      <= 1'b1;
`ifdef SLIDE_ACCEL_EN
                        r_step  <= SW'(STEP);
`endif
                    end
                end
                S_MOVE: begin
                    if (ix == r_tx && iy == r_ty) begin
                        r_state <= S_DONE;
                        on      <= 1'b0;
                        done    <= 1'b1;
                    end else if (frame_tick) begin
                        ix <= w_nx;
                        iy <= w_ny;
`ifdef SLIDE_ACCEL_EN
                        r_step <= (r_step >= SW'(2 * STEP)) ? SW'(4 * STEP)
                                                            : (r_step << 1);
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    on      <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
